// File: rtl/mb_scan_gen_pkg.sv
// Shared types and helpers for the block-scan sequencer and the stages that consume its coordinates.
package idaten_scan_pkg;

  typedef enum logic {
    SCAN_RASTER = 1'b0,
    SCAN_MB_Z   = 1'b1
  } scan_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Places row above col; callers truncate the result to 2*coord_w bits.
  function automatic logic [63:0] pack_mbnumber(input logic [31:0] row,
                                                 input logic [31:0] col,
                                                 input int unsigned coord_w);
    return (64'(row) << coord_w) | 64'(col);
  endfunction

endpackage

// File: rtl/mb_scan_gen_if.sv
// Valid/ready block-coordinate stream from the scan sequencer to a consumer stage.
interface mb_scan_gen_if #(
  parameter int COORD_W = 16
);
  logic                   valid;
  logic                   ready;
  logic [2*COORD_W-1:0]   mbnumber;
  logic [3:0]             blk_idx;
  logic                   last_in_row;
  logic                   last_in_frame;

  modport master (
    output valid, mbnumber, blk_idx, last_in_row, last_in_frame,
    input  ready
  );

  modport slave (
    input  valid, mbnumber, blk_idx, last_in_row, last_in_frame,
    output ready
  );
endinterface

// File: rtl/mb_scan_gen_z_offset.sv
// Pixel offset of a 4x4-block Z-order index inside its macroblock; bit 0/2 select x, bit 1/3 select y.
module mb_z_offset #(
  parameter int BLK     = 4,
  parameter int COORD_W = 16
) (
  input  logic [3:0]         blk_idx,
  output logic [COORD_W-1:0] dy,
  output logic [COORD_W-1:0] dx
);
  assign dx = COORD_W'({blk_idx[2], blk_idx[0]}) * COORD_W'(BLK);
  assign dy = COORD_W'({blk_idx[3], blk_idx[1]}) * COORD_W'(BLK);
endmodule

// File: rtl/mb_scan_gen.sv
// Block-scan sequencer: walks a WIDTH x LENGTH frame in BLK x BLK steps (raster or MB Z-order)
// and presents each block's top-left {row, col} on a valid/ready stream.
module mb_scan_gen
  import idaten_scan_pkg::*;
#(
  parameter int WIDTH   = 1280,
  parameter int LENGTH  = 720,
  parameter int BLK     = 4,
  parameter int COORD_W = 16,
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic               continuous,
  input  logic               abort,
  mb_scan_gen_if.master      bus,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               busy
);
  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t BLK_STEP   = coord_t'(BLK);
  localparam coord_t MB_STEP    = coord_t'(4 * BLK);
  localparam coord_t COL_LAST   = coord_t'(WIDTH - BLK);
  localparam coord_t ROW_LAST   = coord_t'(LENGTH - BLK);
  localparam coord_t MBCOL_LAST = coord_t'(WIDTH - 4 * BLK);
  localparam coord_t MBROW_LAST = coord_t'(LENGTH - 4 * BLK);
  localparam bit     FIRST_LROW   = (WIDTH == BLK);
  localparam bit     FIRST_LFRAME = (WIDTH == BLK) && (LENGTH == BLK);

  // MB mode additionally needs WIDTH and LENGTH to be multiples of 4*BLK.
  if (BLK < 1 || (BLK & (BLK - 1)) != 0 || (WIDTH % BLK) != 0 || (LENGTH % BLK) != 0)
  begin : g_param_check
    $error("mb_scan_gen: BLK must be a power of two dividing WIDTH and LENGTH");
  end

  scan_state_e        state;
  scan_mode_e         mode_q;
  coord_t             row_q, col_q, mb_row_q, mb_col_q;
  logic [3:0]         bidx_q;
  logic               valid_q, lrow_q, lframe_q, done_q, busy_q;
  logic [FRAME_W-1:0] frame_q;

  coord_t     nxt_row, nxt_col, nxt_mb_row, nxt_mb_col, dy, dx;
  logic [3:0] nxt_bidx;
  logic       nxt_lrow, nxt_lframe;

  assign nxt_bidx = (mode_q == SCAN_MB_Z) ? bidx_q + 4'd1 : 4'd0;

  mb_z_offset #(.BLK(BLK), .COORD_W(COORD_W)) u_z_offset (
    .blk_idx (nxt_bidx),
    .dy      (dy),
    .dx      (dx)
  );

  // Coordinates and flags of the block that follows the current one; wraps to {0,0} after the last.
  always_comb begin
    nxt_row    = row_q;
    nxt_col    = col_q;
    nxt_mb_row = mb_row_q;
    nxt_mb_col = mb_col_q;
    nxt_lrow   = 1'b0;
    nxt_lframe = 1'b0;
    if (mode_q == SCAN_RASTER) begin
      if (col_q == COL_LAST) begin
        nxt_col = '0;
        nxt_row = (row_q == ROW_LAST) ? '0 : row_q + BLK_STEP;
      end else begin
        nxt_col = col_q + BLK_STEP;
      end
      nxt_lrow   = (nxt_col == COL_LAST);
      nxt_lframe = nxt_lrow && (nxt_row == ROW_LAST);
    end else begin
      if (bidx_q == 4'd15) begin
        if (mb_col_q == MBCOL_LAST) begin
          nxt_mb_col = '0;
          nxt_mb_row = (mb_row_q == MBROW_LAST) ? '0 : mb_row_q + MB_STEP;
        end else begin
          nxt_mb_col = mb_col_q + MB_STEP;
        end
      end
      nxt_row    = nxt_mb_row + dy;
      nxt_col    = nxt_mb_col + dx;
      nxt_lrow   = (nxt_bidx == 4'd15) && (nxt_mb_col == MBCOL_LAST);
      nxt_lframe = nxt_lrow && (nxt_mb_row == MBROW_LAST);
    end
  end

  // Abort outranks everything but reset; done/frame_cnt follow the final handshake in both exit paths.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mode_q   <= SCAN_RASTER;
      row_q    <= '0;
      col_q    <= '0;
      mb_row_q <= '0;
      mb_col_q <= '0;
      bidx_q   <= '0;
      valid_q  <= 1'b0;
      lrow_q   <= 1'b0;
      lframe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      frame_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        row_q    <= '0;
        col_q    <= '0;
        mb_row_q <= '0;
        mb_col_q <= '0;
        bidx_q   <= '0;
        valid_q  <= 1'b0;
        lrow_q   <= 1'b0;
        lframe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              mode_q   <= scan_mode_e'(mode);
              row_q    <= '0;
              col_q    <= '0;
              mb_row_q <= '0;
              mb_col_q <= '0;
              bidx_q   <= '0;
              valid_q  <= 1'b1;
              lrow_q   <= mode ? 1'b0 : FIRST_LROW;
              lframe_q <= mode ? 1'b0 : FIRST_LFRAME;
              busy_q   <= 1'b1;
            end
          end
          RUN: begin
            if (valid_q && bus.ready) begin
              if (lframe_q) begin
                done_q  <= 1'b1;
                frame_q <= frame_q + 1'b1;
              end
              if (lframe_q && !continuous) begin
                state    <= DONE;
                row_q    <= '0;
                col_q    <= '0;
                mb_row_q <= '0;
                mb_col_q <= '0;
                bidx_q   <= '0;
                valid_q  <= 1'b0;
                lrow_q   <= 1'b0;
                lframe_q <= 1'b0;
              end else begin
                row_q    <= nxt_row;
                col_q    <= nxt_col;
                mb_row_q <= nxt_mb_row;
                mb_col_q <= nxt_mb_col;
                bidx_q   <= nxt_bidx;
                lrow_q   <= nxt_lrow;
                lframe_q <= nxt_lframe;
              end
            end
          end
          DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.valid         = valid_q;
  assign bus.mbnumber      = (2 * COORD_W)'(pack_mbnumber(32'(row_q), 32'(col_q), COORD_W));
  assign bus.blk_idx       = bidx_q;
  assign bus.last_in_row   = lrow_q;
  assign bus.last_in_frame = lframe_q;
  assign done              = done_q;
  assign frame_cnt         = frame_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_mb_scan_gen.sv
// Bench for mb_scan_gen: a 32x16 instance against a frame-order reference with random ready,
// plus a default 1280x720 instance for the mid-frame reset and full-frame run.
module tb_mb_scan_gen;
  localparam int W  = 32;
  localparam int L  = 16;
  localparam int B  = 4;
  localparam int CW = 16;
  localparam int NB = (W / B) * (L / B);

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] col;
    logic [3:0]  bidx;
    logic        lrow;
    logic        lframe;
  } blk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, start, mode, continuous, abort, ready, done, busy;
  logic [7:0] frame_cnt;
  logic       rst2n, start2, done2, busy2;
  logic       tie0 = 1'b0;
  logic [7:0] frame_cnt2;
  bit         rand_ready;

  int   total = 0;
  int   bad = 0;
  int   dones_seen = 0;
  blk_t hs_log[$];
  blk_t seq_r[NB];
  blk_t seq_z[NB];

  mb_scan_gen_if #(.COORD_W(CW)) sif ();
  mb_scan_gen_if #(.COORD_W(CW)) bif ();
  assign sif.ready = ready;
  assign bif.ready = 1'b1;

  mb_scan_gen #(.WIDTH(W), .LENGTH(L), .BLK(B), .COORD_W(CW), .FRAME_W(8)) dut (
    .clk(clk), .reset(rstn), .start(start), .mode(mode), .continuous(continuous),
    .abort(abort), .bus(sif), .done(done), .frame_cnt(frame_cnt), .busy(busy)
  );

  mb_scan_gen #(.WIDTH(1280), .LENGTH(720), .BLK(4), .COORD_W(CW), .FRAME_W(8)) dut_big (
    .clk(clk), .reset(rst2n), .start(start2), .mode(tie0), .continuous(tie0),
    .abort(tie0), .bus(bif), .done(done2), .frame_cnt(frame_cnt2), .busy(busy2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  task automatic applyStimulus(input logic m, input logic c);
    tick();
    hs_log.delete();
    dones_seen = 0;
    mode       = m;
    continuous = c;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic resetSmall();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic waitDone(input int target, input int limit);
    int n = 0;
    while (dones_seen < target && n < limit) begin
      tick();
      n++;
    end
    checkOutput("done_reached", 64'(dones_seen >= target), 64'(1));
  endtask

  // Reference: the frame's block list in scan order, then a cursor into it.
  bit         m_run = 0, m_dphase = 0, m_done = 0, m_mode = 0;
  int         m_idx = 0;
  logic [7:0] m_frames = '0;
  bit         prev_stall = 0;
  blk_t       prev_a;

  always @(negedge clk) begin : compare
    blk_t a, e;
    a = '{row: sif.mbnumber[31:16], col: sif.mbnumber[15:0], bidx: sif.blk_idx,
          lrow: sif.last_in_row, lframe: sif.last_in_frame};
    checkOutput("valid", 64'(sif.valid), 64'(m_run));
    checkOutput("busy", 64'(busy), 64'(m_run || m_dphase));
    checkOutput("done", 64'(done), 64'(m_done));
    checkOutput("frame_cnt", 64'(frame_cnt), 64'(m_frames));
    if (m_run) begin
      e = m_mode ? seq_z[m_idx] : seq_r[m_idx];
      checkOutput("block", 64'(a), 64'(e));
    end
    if (prev_stall) checkOutput("stall_hold", 64'(a), 64'(prev_a));
    prev_stall = sif.valid && !sif.ready && rstn && !abort;
    prev_a     = a;
    if (done === 1'b1) dones_seen++;

    m_done = 0;
    if (!rstn) begin
      m_run = 0; m_dphase = 0; m_idx = 0; m_frames = '0;
    end else if (abort) begin
      m_run = 0; m_dphase = 0; m_idx = 0;
    end else if (m_dphase) begin
      m_dphase = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_idx = 0; m_mode = mode;
      end
    end else if (sif.ready) begin
      hs_log.push_back(a);
      if (m_idx == NB - 1) begin
        m_done = 1;
        m_frames++;
        m_idx = 0;
        if (!continuous) begin
          m_run = 0; m_dphase = 1;
        end
      end else begin
        m_idx++;
      end
    end
  end

  task automatic bigTest();
    int   hs = 0;
    bit   found = 0;
    logic [31:0] last_mb = '0;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    repeat (100) tick();
    rst2n = 1'b0;
    tick();
    rst2n = 1'b1;
    @(negedge clk);
    checkOutput("big_rst_valid", 64'(bif.valid), 64'(0));
    checkOutput("big_rst_mb", 64'(bif.mbnumber), 64'(0));
    checkOutput("big_rst_flags", 64'({bif.blk_idx, bif.last_in_row, bif.last_in_frame}), 64'(0));
    checkOutput("big_rst_misc", 64'({done2, busy2, frame_cnt2}), 64'(0));
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    @(negedge clk);
    checkOutput("big_first_valid", 64'(bif.valid), 64'(1));
    checkOutput("big_first_mb", 64'(bif.mbnumber), 64'(0));
    for (int n = 0; n < 60000 && !found; n++) begin
      if (bif.valid) begin
        hs++;
        if (bif.last_in_frame) begin
          found   = 1;
          last_mb = bif.mbnumber;
        end
      end
      if (!found) @(negedge clk);
    end
    checkOutput("big_found_last", 64'(found), 64'(1));
    checkOutput("big_count", 64'(hs), 64'(57600));
    checkOutput("big_last_mb", 64'(last_mb), 64'({16'd716, 16'd1276}));
    @(negedge clk);
    checkOutput("big_done", 64'({done2, frame_cnt2}), 64'({1'b1, 8'd1}));
  endtask

  initial begin
    int k = 0;
    for (int r = 0; r < L; r += B)
      for (int c = 0; c < W; c += B) begin
        seq_r[k] = '{row: 16'(r), col: 16'(c), bidx: 4'd0, lrow: (c == W - B),
                     lframe: (c == W - B) && (r == L - B)};
        k++;
      end
    k = 0;
    for (int mr = 0; mr < L; mr += 4 * B)
      for (int mc = 0; mc < W; mc += 4 * B)
        for (int i = 0; i < 16; i++) begin
          seq_z[k] = '{row: 16'(mr + B * (2 * ((i >> 3) & 1) + ((i >> 1) & 1))),
                       col: 16'(mc + B * (2 * ((i >> 2) & 1) + (i & 1))),
                       bidx: 4'(i), lrow: (i == 15) && (mc == W - 4 * B),
                       lframe: (i == 15) && (mc == W - 4 * B) && (mr == L - 4 * B)};
          k++;
        end

    rstn = 0; rst2n = 0; start = 0; start2 = 0; mode = 0; continuous = 0; abort = 0;
    ready = 1; rand_ready = 0;
    checkOutput("model_z4", 64'({seq_z[4].row, seq_z[4].col}), 64'({16'd0, 16'd8}));
    checkOutput("model_r9", 64'({seq_r[9].row, seq_r[9].col}), 64'({16'd4, 16'd4}));
    repeat (3) tick();
    rstn = 1; rst2n = 1;
    @(negedge clk);
    checkOutput("rst_outputs", 64'({sif.valid, sif.mbnumber, sif.blk_idx, sif.last_in_row,
                                    sif.last_in_frame, done, busy, frame_cnt}), 64'(0));

    $display("[TB] raster, ready high");
    applyStimulus(1'b0, 1'b0);
    waitDone(1, 200);
    @(negedge clk);
    checkOutput("r_count", 64'(hs_log.size()), 64'(32));
    checkOutput("r_b1", 64'({hs_log[1].row, hs_log[1].col}), 64'({16'd0, 16'd4}));
    checkOutput("r_b8", 64'({hs_log[8].row, hs_log[8].col}), 64'({16'd4, 16'd0}));
    checkOutput("r_b31", 64'({hs_log[31].row, hs_log[31].col}), 64'({16'd12, 16'd28}));
    checkOutput("r_lrow", 64'({hs_log[6].lrow, hs_log[7].lrow, hs_log[31].lframe}), 64'(3'b011));
    checkOutput("r_idle", 64'({busy, frame_cnt}), 64'({1'b0, 8'd1}));

    $display("[TB] MB Z-order");
    resetSmall();
    applyStimulus(1'b1, 1'b0);
    waitDone(1, 200);
    @(negedge clk);
    checkOutput("z_first5", {hs_log[0].col[7:0], hs_log[1].col[7:0], hs_log[2].row[7:0],
                             hs_log[3].row[7:0], hs_log[3].col[7:0], hs_log[4].col[7:0], 16'd0},
                {8'd0, 8'd4, 8'd4, 8'd4, 8'd4, 8'd8, 16'd0});
    checkOutput("z_b16", 64'({hs_log[16].row, hs_log[16].col, hs_log[16].bidx}), 64'({16'd0, 16'd16, 4'd0}));
    checkOutput("z_b31", 64'({hs_log[31].row, hs_log[31].col, hs_log[31].lframe}), 64'({16'd12, 16'd28, 1'b1}));

    $display("[TB] raster, random ready");
    resetSmall();
    rand_ready = 1;
    applyStimulus(1'b0, 1'b0);
    waitDone(1, 500);
    rand_ready = 0;
    @(negedge clk);
    checkOutput("rand_count", 64'(hs_log.size()), 64'(32));
    for (int i = 0; i < NB; i++) checkOutput("rand_seq", 64'(hs_log[i]), 64'(seq_r[i]));

    $display("[TB] continuous, three frames");
    resetSmall();
    applyStimulus(1'b0, 1'b1);
    waitDone(2, 300);
    continuous = 1'b0;
    waitDone(3, 300);
    @(negedge clk);
    checkOutput("c_frames", 64'({dones_seen, frame_cnt}), 64'({32'd3, 8'd3}));
    checkOutput("c_count", 64'(hs_log.size()), 64'(96));
    checkOutput("c_wrap", 64'({hs_log[31].row, hs_log[31].col, hs_log[32].row, hs_log[32].col}),
                {16'd12, 16'd28, 16'd0, 16'd0});

    $display("[TB] abort at block 10");
    resetSmall();
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 100 && hs_log.size() < 10; n++) tick();
    checkOutput("abort_reach", 64'(hs_log.size()), 64'(10));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_state", 64'({sif.valid, busy, done, frame_cnt, sif.mbnumber}), 64'(0));
    applyStimulus(1'b0, 1'b0);
    waitDone(1, 200);
    @(negedge clk);
    checkOutput("abort_restart", 64'({hs_log[0].row, hs_log[0].col, 8'(hs_log.size())}), 64'({32'd0, 8'd32}));
    checkOutput("abort_frames", 64'(frame_cnt), 64'(1));

    $display("[TB] 1280x720 mid-frame reset");
    bigTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
